// File: rtl/basic_i2c_master_core.sv
// Single-transaction I2C master: one register write or one register read
// (via repeated START) against a 7-bit-addressed slave, open-drain pins.
module basic_i2c_master_core #(
  parameter int SYS_CLOCK_FREQ     = 100_000_000,
  parameter int SCL_FREQ           = 100_000,
  parameter int DEV_ADDR_WIDTH     = 7,
  parameter int DEV_REG_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH         = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_trans_i,
  input  logic                          read_i,
  input  logic [DEV_ADDR_WIDTH-1:0]     dev_addr_i,
  input  logic [DEV_REG_ADDR_WIDTH-1:0] dev_reg_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  output logic [DATA_WIDTH-1:0]         read_data_o,
  output logic                          busy_o,
  inout  wire logic                     i2c_serial_data,
  inout  wire logic                     i2c_serial_clk
);

  localparam int QRAW   = (SYS_CLOCK_FREQ + 4*SCL_FREQ - 1) / (4*SCL_FREQ);
  localparam int QTICKS = (QRAW < 1) ? 1 : QRAW;
  localparam int CW     = (QTICKS > 1) ? $clog2(QTICKS) : 1;
  localparam int RBYTES = DEV_REG_ADDR_WIDTH / 8;
  localparam int DBYTES = DATA_WIDTH / 8;
  localparam logic [CW-1:0] QLAST = CW'(QTICKS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK1, S_REG, S_ACK2, S_WDATA,
    S_ACK3, S_RSTART, S_ADDR_R, S_ACK4, S_RDATA, S_MACK, S_STOP
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0]                 r_cnt;
  logic [1:0]                    r_q;
  logic [2:0]                    r_bit;
  logic [7:0]                    r_byte;
  logic                          r_read;
  logic [DEV_ADDR_WIDTH-1:0]     r_dev;
  logic [DEV_REG_ADDR_WIDTH-1:0] r_reg_sh;
  logic [DATA_WIDTH-1:0]         r_wd_sh;
  logic [DATA_WIDTH-1:0]         r_rd_sh;
  logic [DATA_WIDTH-1:0]         r_rdata;
  logic                          r_sda_low;
  logic                          r_scl_low;
  logic                          r_sda_smp;

  logic                  w_sda_in, w_scl_in;
  logic                  w_hold, w_tick, w_bit_end;
  logic                  w_sda_low, w_scl_low;
  logic                  w_data_st, w_ack_st, w_same_field;
  logic                  w_last_reg, w_last_wr, w_last_rd;
  logic [DEV_ADDR_WIDTH:0] w_addr_byte;

  assign i2c_serial_data = r_sda_low ? 1'b0 : 1'bz;
  assign i2c_serial_clk  = r_scl_low ? 1'b0 : 1'bz;
  assign w_sda_in        = i2c_serial_data;
  assign w_scl_in        = i2c_serial_clk;

  assign busy_o      = (r_state != S_IDLE);
  assign read_data_o = r_rdata;

  // A released SCL that still reads low is a slave stretching the clock.
  assign w_hold    = busy_o && !r_scl_low && !w_scl_in;
  assign w_tick    = busy_o && !w_hold && (r_cnt == QLAST);
  assign w_bit_end = w_tick && (r_q == 2'd3);

  assign w_last_reg  = (r_byte == 8'(RBYTES - 1));
  assign w_last_wr   = (r_byte == 8'(DBYTES - 1));
  assign w_last_rd   = (r_byte == 8'(DBYTES - 1));
  assign w_addr_byte = {r_dev, (r_state == S_ADDR_R)};

  assign w_data_st = r_state inside {S_ADDR_W, S_REG, S_WDATA,
                                     S_ADDR_R, S_RDATA};
  assign w_ack_st  = r_state inside {S_ACK1, S_ACK2, S_ACK3,
                                     S_ACK4, S_MACK};
  assign w_same_field = (r_state == S_ACK2 && w_next == S_REG)
                     || (r_state == S_ACK3 && w_next == S_WDATA)
                     || (r_state == S_MACK && w_next == S_RDATA);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_trans_i) w_next = S_START;
      S_START:  if (w_bit_end) w_next = S_ADDR_W;
      S_ADDR_W: if (w_bit_end && r_bit == 3'd7) w_next = S_ACK1;
      S_ACK1:   if (w_bit_end) w_next = r_sda_smp ? S_STOP : S_REG;
      S_REG:    if (w_bit_end && r_bit == 3'd7) w_next = S_ACK2;
      S_ACK2:
        if (w_bit_end) begin
          if (r_sda_smp)       w_next = S_STOP;
          else if (!w_last_reg) w_next = S_REG;
          else if (r_read)     w_next = S_RSTART;
          else                 w_next = S_WDATA;
        end
      S_WDATA:  if (w_bit_end && r_bit == 3'd7) w_next = S_ACK3;
      S_ACK3:
        if (w_bit_end)
          w_next = (r_sda_smp || w_last_wr) ? S_STOP : S_WDATA;
      S_RSTART: if (w_bit_end) w_next = S_ADDR_R;
      S_ADDR_R: if (w_bit_end && r_bit == 3'd7) w_next = S_ACK4;
      S_ACK4:   if (w_bit_end) w_next = r_sda_smp ? S_STOP : S_RDATA;
      S_RDATA:  if (w_bit_end && r_bit == 3'd7) w_next = S_MACK;
      S_MACK:   if (w_bit_end) w_next = w_last_rd ? S_STOP : S_RDATA;
      S_STOP:   if (w_bit_end) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sda_low = 1'b0;
    w_scl_low = 1'b0;
    case (r_state)
      S_START: w_sda_low = r_q[1];
      S_ADDR_W, S_ADDR_R: begin
        w_scl_low = !r_q[1];
        w_sda_low = !w_addr_byte[~r_bit];
      end
      S_REG: begin
        w_scl_low = !r_q[1];
        w_sda_low = !r_reg_sh[DEV_REG_ADDR_WIDTH-1];
      end
      S_WDATA: begin
        w_scl_low = !r_q[1];
        w_sda_low = !r_wd_sh[DATA_WIDTH-1];
      end
      S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_RDATA:
        w_scl_low = !r_q[1];
      S_MACK: begin
        w_scl_low = !r_q[1];
        w_sda_low = !w_last_rd;
      end
      S_RSTART: begin
        w_scl_low = (r_q == 2'd0);
        w_sda_low = r_q[1];
      end
      S_STOP: begin
        w_scl_low = (r_q == 2'd0);
        w_sda_low = !r_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt     <= '0;
      r_q       <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_read    <= 1'b0;
      r_dev     <= '0;
      r_reg_sh  <= '0;
      r_wd_sh   <= '0;
      r_rd_sh   <= '0;
      r_rdata   <= '0;
      r_sda_low <= 1'b0;
      r_scl_low <= 1'b0;
      r_sda_smp <= 1'b0;
    end else begin
      r_sda_low <= w_sda_low;
      r_scl_low <= w_scl_low;
      if (r_state == S_IDLE) begin
        r_cnt  <= '0;
        r_q    <= '0;
        r_bit  <= '0;
        r_byte <= '0;
        if (start_trans_i) begin
          r_read   <= read_i;
          r_dev    <= dev_addr_i;
          r_reg_sh <= dev_reg_addr_i;
          r_wd_sh  <= wr_data_i;
        end
      end else begin
        if (!w_hold) r_cnt <= (r_cnt == QLAST) ? '0 : r_cnt + 1'b1;
        if (w_tick) r_q <= r_q + 2'd1;
        if (w_tick && r_q == 2'd2) r_sda_smp <= w_sda_in;
        if (w_bit_end) begin
          r_bit <= w_data_st ? r_bit + 3'd1 : 3'd0;
          if (w_ack_st) r_byte <= w_same_field ? r_byte + 8'd1 : 8'd0;
          if (r_state == S_REG)   r_reg_sh <= r_reg_sh << 1;
          if (r_state == S_WDATA) r_wd_sh  <= r_wd_sh << 1;
          if (r_state == S_RDATA)
            r_rd_sh <= {r_rd_sh[DATA_WIDTH-2:0], r_sda_smp};
          if (r_state == S_MACK && w_next == S_STOP) r_rdata <= r_rd_sh;
        end
      end
    end
  end

endmodule

// File: tb/tb_basic_i2c_master_core.sv
// Directed bench for basic_i2c_master_core with a behavioural slave
// that logs START/STOP, received bytes and the master's ACK/NACK.
module tb_basic_i2c_master_core;

  localparam int EV_S = 256;
  localparam int EV_P = 512;
  localparam int EV_A = 768;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_trans_i = 1'b0;
  logic       read_i = 1'b0;
  logic [6:0] dev_addr_i = '0;
  logic [7:0] dev_reg_addr_i = '0;
  logic [7:0] wr_data_i = '0;
  logic [7:0] read_data_o;
  logic       busy_o;

  wire sda_w;
  wire scl_w;
  pullup (sda_w);
  pullup (scl_w);

  logic s_sda_drv = 1'b0;
  logic s_scl_drv = 1'b0;
  assign sda_w = s_sda_drv ? 1'b0 : 1'bz;
  assign scl_w = s_scl_drv ? 1'b0 : 1'bz;

  basic_i2c_master_core #(
    .SYS_CLOCK_FREQ(100_000_000),
    .SCL_FREQ(10_000_000),
    .DEV_ADDR_WIDTH(7),
    .DEV_REG_ADDR_WIDTH(8),
    .DATA_WIDTH(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_trans_i(start_trans_i),
    .read_i(read_i),
    .dev_addr_i(dev_addr_i),
    .dev_reg_addr_i(dev_reg_addr_i),
    .wr_data_i(wr_data_i),
    .read_data_o(read_data_o),
    .busy_o(busy_o),
    .i2c_serial_data(sda_w),
    .i2c_serial_clk(scl_w)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int ev[$];
  int ex[$];

  logic [7:0] txb = 8'h3C;
  logic       nack_first = 1'b0;
  logic       stretch_en = 1'b0;
  logic       stretch_done = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int got,
                             input int lo, input int hi);
    check($sformatf("%s=%0d", tag, got),
          int'(got >= lo && got <= hi), 1);
  endtask

  task automatic cmp_events(input string tag);
    check({tag, "_count"}, ev.size(), ex.size());
    for (int i = 0; i < ex.size() && i < ev.size(); i++)
      check($sformatf("%s[%0d]", tag, i), ev[i], ex[i]);
  endtask

  task automatic start_txn(input logic rd, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk);
    read_i         = rd;
    dev_addr_i     = dev;
    dev_reg_addr_i = ra;
    wr_data_i      = wd;
    start_trans_i  = 1'b1;
    @(negedge clk);
    start_trans_i  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, int'(busy_o), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
    end
  end

  // Slave: oversamples both lines on the falling system clock edge.
  initial begin : slave
    logic scl, sda, p_scl, p_sda, tx, next_tx, first;
    logic [7:0] sh;
    int bitcnt, stretch;
    p_scl = 1'b1; p_sda = 1'b1; tx = 1'b0; next_tx = 1'b0;
    first = 1'b0; sh = '0; bitcnt = 0; stretch = 0;
    forever begin
      @(negedge clk);
      scl = scl_w;
      sda = sda_w;
      if (stretch > 0) begin
        stretch--;
        if (stretch == 0) s_scl_drv = 1'b0;
      end
      if (p_scl && scl && p_sda && !sda) begin
        ev.push_back(EV_S);
        bitcnt = 0; first = 1'b1; tx = 1'b0; next_tx = 1'b0;
        s_sda_drv = 1'b0;
      end else if (p_scl && scl && !p_sda && sda) begin
        ev.push_back(EV_P);
        bitcnt = 0; first = 1'b0; tx = 1'b0; next_tx = 1'b0;
        s_sda_drv = 1'b0;
      end else if (!p_scl && scl) begin
        if (bitcnt < 8) sh = {sh[6:0], sda};
        else if (tx) begin
          ev.push_back(EV_A + int'(sda));
          if (sda) next_tx = 1'b0;
        end
        bitcnt++;
      end else if (p_scl && !scl) begin
        if (bitcnt == 8) begin
          if (tx) s_sda_drv = 1'b0;
          else begin
            ev.push_back(int'(sh));
            s_sda_drv = !(nack_first && first);
            if (first) next_tx = sh[0] && !nack_first;
            first = 1'b0;
          end
        end else if (bitcnt == 9) begin
          bitcnt = 0;
          tx = next_tx;
          s_sda_drv = tx && !txb[7];
        end else if (tx) begin
          s_sda_drv = !txb[7-bitcnt];
        end
        if (stretch_en && !stretch_done && bitcnt == 3) begin
          stretch_done = 1'b1;
          s_scl_drv = 1'b1;
          stretch = 20;
        end
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy_o), 0);
    check("rst_rdata", int'(read_data_o), 0);
    check("rst_sda", int'(sda_w), 1);
    check("rst_scl", int'(scl_w), 1);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);

    ev.delete(); busy_cnt = 0;
    start_txn(1'b0, 7'h55, 8'hAA, 8'hFF);
    wait_idle("wr");
    ex = '{EV_S, 'hAA, 'hAA, 'hFF, EV_P};
    cmp_events("wr_ev");
    check_range("wr_busy", busy_cnt, 346, 350);
    check("wr_rdata", int'(read_data_o), 0);

    ev.delete(); busy_cnt = 0; txb = 8'h3C;
    start_txn(1'b1, 7'h55, 8'h10, 8'h00);
    wait_idle("rd");
    ex = '{EV_S, 'hAA, 'h10, EV_S, 'hAB, EV_A + 1, EV_P};
    cmp_events("rd_ev");
    check_range("rd_busy", busy_cnt, 466, 470);
    check("rd_rdata", int'(read_data_o), 'h3C);

    ev.delete(); busy_cnt = 0; txb = 8'h99; nack_first = 1'b1;
    start_txn(1'b1, 7'h55, 8'h10, 8'h00);
    wait_idle("nack");
    nack_first = 1'b0;
    ex = '{EV_S, 'hAA, EV_P};
    cmp_events("nack_ev");
    check_range("nack_busy", busy_cnt, 130, 134);
    check("nack_rdata", int'(read_data_o), 'h3C);

    ev.delete(); busy_cnt = 0;
    start_txn(1'b0, 7'h55, 8'h21, 8'h5A);
    repeat (100) @(negedge clk);
    read_i = 1'b1; dev_addr_i = 7'h11;
    dev_reg_addr_i = 8'h22; wr_data_i = 8'h33;
    start_trans_i = 1'b1;
    @(negedge clk);
    start_trans_i = 1'b0;
    wait_idle("rej");
    repeat (50) @(negedge clk);
    check("rej_idle", int'(busy_o), 0);
    ex = '{EV_S, 'hAA, 'h21, 'h5A, EV_P};
    cmp_events("rej_ev");
    check_range("rej_busy", busy_cnt, 346, 350);

    ev.delete(); busy_cnt = 0; stretch_en = 1'b1;
    start_txn(1'b0, 7'h55, 8'h77, 8'hC3);
    wait_idle("str");
    stretch_en = 1'b0;
    ex = '{EV_S, 'hAA, 'h77, 'hC3, EV_P};
    cmp_events("str_ev");
    check_range("str_busy", busy_cnt, 352, 390);

    start_txn(1'b0, 7'h55, 8'hAA, 8'hFF);
    repeat (40) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("mrst_busy", int'(busy_o), 0);
    check("mrst_sda", int'(sda_w), 1);
    check("mrst_scl", int'(scl_w), 1);
    check("mrst_rdata", int'(read_data_o), 0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
